// File: rtl/rbm_act_sampler.sv
// RBM activation sampler: bias add, hard-sigmoid and binary hidden-state draw, one element per clock.
// Optional build macro STOCHASTIC_SAMPLE_EN selects LFSR sampling instead of a fixed 0.5 threshold.
module rbm_act_sampler #(
    parameter int          ROWS      = 15,
    parameter int          COLS      = 15,
    parameter int          BITLENGTH = 8,
    parameter int          FRAC      = 4,
    parameter logic [15:0] SEED      = 16'hACE1
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               in_valid,
    output logic                               in_ready,
    input  logic [ROWS*COLS*BITLENGTH-1:0]     prod,
    input  logic [COLS*BITLENGTH-1:0]          bias,
    output logic                               out_valid,
    input  logic                               out_ready,
    output logic [ROWS*COLS*BITLENGTH-1:0]     prob,
    output logic [ROWS*COLS-1:0]               hid
);

    localparam int N    = ROWS * COLS;
    localparam int IDXW = (N > 1) ? $clog2(N) : 1;
    localparam int COLW = (COLS > 1) ? $clog2(COLS) : 1;
    localparam int SH   = BITLENGTH - FRAC - 2;
    localparam int TW   = 2 * BITLENGTH + 2;
    localparam logic signed [TW-1:0] HALF = TW'(1 << (BITLENGTH - 1));

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t state_q, state_d;

    logic [ROWS*COLS*BITLENGTH-1:0] prod_q, prob_q;
    logic [COLS*BITLENGTH-1:0]      bias_q;
    logic [ROWS*COLS-1:0]           hid_q;
    logic [IDXW-1:0]                idx_q;
    logic [COLW-1:0]                col_q;
    logic                           accept;
    logic                           last;

    logic signed [BITLENGTH-1:0] elem_prod, elem_bias, x;
    logic signed [BITLENGTH:0]   s;
    logic signed [TW-1:0]        xe, t;
    logic [BITLENGTH-1:0]        p;
    logic                        h;

    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    assign last = (idx_q == IDXW'(N - 1));

    always_comb begin
        state_d   = state_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        accept    = 1'b0;
        case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    accept  = 1'b1;
                    state_d = RUN;
                end
            end
            RUN: begin
                if (last) state_d = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Saturating bias add, then x/4 + 0.5 rescaled to the full unsigned output range.
    always_comb begin
        elem_prod = prod_q[32'(idx_q) * BITLENGTH +: BITLENGTH];
        elem_bias = bias_q[32'(col_q) * BITLENGTH +: BITLENGTH];
        s = {elem_prod[BITLENGTH-1], elem_prod} + {elem_bias[BITLENGTH-1], elem_bias};
        if (!s[BITLENGTH] && s[BITLENGTH-1])
            x = {1'b0, {(BITLENGTH-1){1'b1}}};
        else if (s[BITLENGTH] && !s[BITLENGTH-1])
            x = {1'b1, {(BITLENGTH-1){1'b0}}};
        else
            x = s[BITLENGTH-1:0];
        xe = {{(TW-BITLENGTH){x[BITLENGTH-1]}}, x};
        t  = (xe <<< SH) + HALF;
        if (t[TW-1])
            p = '0;
        else if (|t[TW-2:BITLENGTH])
            p = '1;
        else
            p = t[BITLENGTH-1:0];
    end

`ifdef STOCHASTIC_SAMPLE_EN
    localparam logic [15:0] SEED_EFF = (SEED == 16'h0000) ? 16'hACE1 : SEED;
    logic [15:0] lfsr_q;

    // Taps 16,14,13,11; steps only on processed elements so a seed gives a repeatable frame sequence.
    always_ff @(posedge clk) begin
        if (rst)
            lfsr_q <= SEED_EFF;
        else if (state_q == RUN)
            lfsr_q <= {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
    end

    assign h = (lfsr_q[BITLENGTH-1:0] < p);
`else
    assign h = p[BITLENGTH-1];
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            prod_q <= '0;
            bias_q <= '0;
            prob_q <= '0;
            hid_q  <= '0;
            idx_q  <= '0;
            col_q  <= '0;
        end else if (accept) begin
            prod_q <= prod;
            bias_q <= bias;
            idx_q  <= '0;
            col_q  <= '0;
        end else if (state_q == RUN) begin
            prob_q[32'(idx_q) * BITLENGTH +: BITLENGTH] <= p;
            hid_q[idx_q] <= h;
            idx_q <= last ? '0 : idx_q + 1'b1;
            col_q <= (col_q == COLW'(COLS - 1)) ? '0 : col_q + 1'b1;
        end
    end

    assign prob = prob_q;
    assign hid  = hid_q;

endmodule

// File: tb/tb_rbm_act_sampler.sv
// Directed bench for rbm_act_sampler at ROWS=COLS=2, BITLENGTH=8, FRAC=4.
// Hidden-state values are checked exactly only when STOCHASTIC_SAMPLE_EN is undefined.
module tb_rbm_act_sampler;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] prod;
    logic [15:0] bias;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] prob;
    logic [3:0]  hid;

    int checks = 0;
    int errors = 0;
    int lat;

    rbm_act_sampler #(
        .ROWS(2), .COLS(2), .BITLENGTH(8), .FRAC(4), .SEED(16'hACE1)
    ) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .prod(prod), .bias(bias),
        .out_valid(out_valid), .out_ready(out_ready),
        .prob(prob), .hid(hid)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    // Offers a frame, scrambles the inputs once accepted, returns cycles from accept edge to out_valid.
    task automatic applyStimulus(input logic [31:0] p, input logic [15:0] b, output int latency);
        int guard;
        prod = p;
        bias = b;
        in_valid = 1'b1;
        guard = 0;
        while (!in_ready && guard < 20) begin
            tick();
            guard++;
        end
        tick();
        in_valid = 1'b0;
        prod = ~p;
        bias = ~b;
        latency = 1;
        while (!out_valid && latency < 50) begin
            tick();
            latency++;
        end
    endtask

    task automatic finishFrame();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

`ifdef STOCHASTIC_SAMPLE_EN
    logic [3:0] seq1 [256];
    int ones, bad_lat, nonzero, diffs;
`endif

    initial begin
        clk = 1'b0;
        rst = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b0;
        prod = '0;
        bias = '0;
        tick();
        tick();
        rst = 1'b0;

        checkOutput("reset_in_ready", 32'(in_ready), 32'd1);
        checkOutput("reset_out_valid", 32'(out_valid), 32'd0);
        checkOutput("reset_prob", prob, 32'd0);
        checkOutput("reset_hid", 32'(hid), 32'd0);

        // Plain sigmoid points, zero bias
        applyStimulus(32'h807FF010, 16'h0000, lat);
        checkOutput("basic_latency", 32'(lat), 32'd5);
        checkOutput("basic_prob", prob, 32'h00FF40C0);
`ifndef STOCHASTIC_SAMPLE_EN
        checkOutput("basic_hid", 32'(hid), 32'h5);
`endif
        checkOutput("basic_in_ready_done", 32'(in_ready), 32'd0);
        finishFrame();
        checkOutput("basic_out_valid_after", 32'(out_valid), 32'd0);
        checkOutput("basic_in_ready_after", 32'(in_ready), 32'd1);

        // Saturation in both directions with per-column bias
        applyStimulus(32'hC040807F, 16'h807F, lat);
        checkOutput("sat_latency", 32'(lat), 32'd5);
        checkOutput("sat_prob", prob, 32'h00FF00FF);
`ifndef STOCHASTIC_SAMPLE_EN
        checkOutput("sat_hid", 32'(hid), 32'h5);
`endif
        finishFrame();

        // Non-saturating bias mix, then hold/handshake behaviour
        applyStimulus(32'h20F80800, 16'hF008, lat);
        checkOutput("mix_latency", 32'(lat), 32'd5);
        checkOutput("mix_prob", prob, 32'hC08060A0);
`ifndef STOCHASTIC_SAMPLE_EN
        checkOutput("mix_hid", 32'(hid), 32'hD);
`endif
        prod = 32'hC040807F;
        bias = 16'h807F;
        in_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            checkOutput("hold_in_ready", 32'(in_ready), 32'd0);
            checkOutput("hold_out_valid", 32'(out_valid), 32'd1);
            checkOutput("hold_prob", prob, 32'hC08060A0);
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        checkOutput("release_in_ready", 32'(in_ready), 32'd1);
        checkOutput("release_out_valid", 32'(out_valid), 32'd0);
        tick();
        in_valid = 1'b0;
        checkOutput("b2b_accepted", 32'(in_ready), 32'd0);
        lat = 1;
        while (!out_valid && lat < 50) begin
            tick();
            lat++;
        end
        checkOutput("b2b_latency", 32'(lat), 32'd5);
        checkOutput("b2b_prob", prob, 32'h00FF00FF);
        finishFrame();

        // Reset during the second RUN cycle discards the partial frame
        prod = 32'h807FF010;
        bias = 16'h0000;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        checkOutput("partial_elem0", prob & 32'hFF, 32'hC0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checkOutput("midrst_in_ready", 32'(in_ready), 32'd1);
        checkOutput("midrst_out_valid", 32'(out_valid), 32'd0);
        checkOutput("midrst_prob", prob, 32'd0);
        checkOutput("midrst_hid", 32'(hid), 32'd0);
        applyStimulus(32'h807FF010, 16'h0000, lat);
        checkOutput("post_rst_latency", 32'(lat), 32'd5);
        checkOutput("post_rst_prob", prob, 32'h00FF40C0);
`ifndef STOCHASTIC_SAMPLE_EN
        checkOutput("post_rst_hid", 32'(hid), 32'h5);
`endif
        finishFrame();

`ifdef STOCHASTIC_SAMPLE_EN
        // p=0 must never sample a one
        bad_lat = 0;
        nonzero = 0;
        for (int f = 0; f < 256; f++) begin
            applyStimulus(32'h80808080, 16'h8080, lat);
            if (lat != 5) bad_lat++;
            if (hid != 4'h0) nonzero++;
            finishFrame();
        end
        checkOutput("stoch_p0_nonzero", 32'(nonzero), 32'd0);
        checkOutput("stoch_p0_latency", 32'(bad_lat), 32'd0);

        // p=192 gives about 3/4 ones, repeatable from the same seed
        rst = 1'b1;
        tick();
        rst = 1'b0;
        ones = 0;
        for (int f = 0; f < 256; f++) begin
            applyStimulus(32'h10101010, 16'h0000, lat);
            seq1[f] = hid;
            if (hid[0]) ones++;
            finishFrame();
        end
        checkOutput("stoch_p192_ones_in_range", 32'(ones >= 160 && ones <= 224), 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        diffs = 0;
        for (int f = 0; f < 256; f++) begin
            applyStimulus(32'h10101010, 16'h0000, lat);
            if (hid !== seq1[f]) diffs++;
            finishFrame();
        end
        checkOutput("stoch_repeatable", 32'(diffs), 32'd0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
